// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - button bit map, scancodes and decode helpers for arcade_input_mapper
package arcade_input_pkg;

    localparam int BTN_W        = 12;
    localparam int BTN_UP       = 0;
    localparam int BTN_DOWN     = 1;
    localparam int BTN_LEFT     = 2;
    localparam int BTN_RIGHT    = 3;
    localparam int BTN_FIRE_A   = 4;
    localparam int BTN_FIRE_B   = 5;
    localparam int BTN_FIRE_C   = 6;
    localparam int BTN_FIRE_D   = 7;
    localparam int BTN_START    = 8;
    localparam int BTN_COIN     = 9;
    localparam int BTN_SERVICE  = 10;

    // Key table carries one extra bit so the second start key is tracked apart from the first.
    localparam int KEY_W         = 13;
    localparam int KEY_ALT_START = 12;

    localparam logic [7:0] SC_ARROW_UP     = 8'h75;
    localparam logic [7:0] SC_ARROW_DOWN   = 8'h72;
    localparam logic [7:0] SC_ARROW_LEFT   = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT  = 8'h74;
    localparam logic [7:0] SC_P0_FIRE_A    = 8'h14;
    localparam logic [7:0] SC_P0_FIRE_B    = 8'h11;
    localparam logic [7:0] SC_P0_FIRE_C    = 8'h29;
    localparam logic [7:0] SC_P0_FIRE_D    = 8'h12;
    localparam logic [7:0] SC_P0_START     = 8'h05;
    localparam logic [7:0] SC_P0_START_ALT = 8'h16;
    localparam logic [7:0] SC_P0_COIN      = 8'h2E;
    localparam logic [7:0] SC_P1_UP        = 8'h2D;
    localparam logic [7:0] SC_P1_DOWN      = 8'h2B;
    localparam logic [7:0] SC_P1_LEFT      = 8'h23;
    localparam logic [7:0] SC_P1_RIGHT     = 8'h34;
    localparam logic [7:0] SC_P1_FIRE_A    = 8'h1C;
    localparam logic [7:0] SC_P1_FIRE_B    = 8'h1B;
    localparam logic [7:0] SC_P1_FIRE_C    = 8'h15;
    localparam logic [7:0] SC_P1_FIRE_D    = 8'h1D;
    localparam logic [7:0] SC_P1_START     = 8'h06;
    localparam logic [7:0] SC_P1_START_ALT = 8'h1E;
    localparam logic [7:0] SC_P1_COIN      = 8'h36;

    typedef struct packed {
        logic       valid;
        logic [1:0] player;
        logic [3:0] idx;
    } key_map_t;

    function automatic key_map_t map_entry(input int player, input int idx);
        return '{valid: 1'b1, player: 2'(player), idx: 4'(idx)};
    endfunction

    function automatic key_map_t key_map(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '0;
        if (ext) begin
            case (code)
                SC_ARROW_UP:    m = map_entry(0, BTN_UP);
                SC_ARROW_DOWN:  m = map_entry(0, BTN_DOWN);
                SC_ARROW_LEFT:  m = map_entry(0, BTN_LEFT);
                SC_ARROW_RIGHT: m = map_entry(0, BTN_RIGHT);
                default:        m = '0;
            endcase
        end else begin
            case (code)
                SC_P0_FIRE_A:    m = map_entry(0, BTN_FIRE_A);
                SC_P0_FIRE_B:    m = map_entry(0, BTN_FIRE_B);
                SC_P0_FIRE_C:    m = map_entry(0, BTN_FIRE_C);
                SC_P0_FIRE_D:    m = map_entry(0, BTN_FIRE_D);
                SC_P0_START:     m = map_entry(0, BTN_START);
                SC_P0_START_ALT: m = map_entry(0, KEY_ALT_START);
                SC_P0_COIN:      m = map_entry(0, BTN_COIN);
                SC_P1_UP:        m = map_entry(1, BTN_UP);
                SC_P1_DOWN:      m = map_entry(1, BTN_DOWN);
                SC_P1_LEFT:      m = map_entry(1, BTN_LEFT);
                SC_P1_RIGHT:     m = map_entry(1, BTN_RIGHT);
                SC_P1_FIRE_A:    m = map_entry(1, BTN_FIRE_A);
                SC_P1_FIRE_B:    m = map_entry(1, BTN_FIRE_B);
                SC_P1_FIRE_C:    m = map_entry(1, BTN_FIRE_C);
                SC_P1_FIRE_D:    m = map_entry(1, BTN_FIRE_D);
                SC_P1_START:     m = map_entry(1, BTN_START);
                SC_P1_START_ALT: m = map_entry(1, KEY_ALT_START);
                SC_P1_COIN:      m = map_entry(1, BTN_COIN);
                default:         m = '0;
            endcase
        end
        return m;
    endfunction

    // Player 1's start lives on joystick bit 9; everyone else uses bit 8.
    function automatic logic [BTN_W-1:0] joy_to_btn(input logic [15:0] j, input logic is_p1);
        logic [BTN_W-1:0] b;
        b              = '0;
        b[BTN_UP]      = j[3];
        b[BTN_DOWN]    = j[2];
        b[BTN_LEFT]    = j[1];
        b[BTN_RIGHT]   = j[0];
        b[BTN_FIRE_A]  = j[4];
        b[BTN_FIRE_B]  = j[5];
        b[BTN_FIRE_C]  = j[7];
        b[BTN_FIRE_D]  = j[6];
        b[BTN_START]   = is_p1 ? j[9] : j[8];
        b[BTN_COIN]    = j[10];
        b[BTN_SERVICE] = j[11];
        return b;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_stretcher.sv
// rtl/arcade_input_mapper_coin_stretcher.sv - per-player coin pulse stretcher
module coin_stretcher #(
    parameter int COIN_MIN_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic coin_o
);

    localparam int CW = (COIN_MIN_CYCLES > 1) ? $clog2(COIN_MIN_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          raw_q;

    // A fresh rising edge always reloads, even mid-count.
    always_comb begin
        cnt_d = cnt_q;
        if (raw_i && !raw_q) begin
            cnt_d = CW'(COIN_MIN_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            raw_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            raw_q <= raw_i;
        end
    end

    assign coin_o = raw_i | (cnt_q != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick input merge, coin stretch, DIP/mod latch (optional AUTOFIRE_EN)
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_DIP_BANKS   = 8,
    parameter int DIP_INDEX       = 254,
    parameter int MOD_INDEX       = 1,
    parameter int COIN_MIN_CYCLES = 1250000,
    parameter int AUTOFIRE_PERIOD = 2083333
) (
    input  logic                         clk_sys,
    input  logic                         RESET_L,
    input  logic [10:0]                  ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]    joy,
    input  logic                         joy_merge,
    input  logic                         ioctl_wr,
    input  logic [7:0]                   ioctl_index,
    input  logic [24:0]                  ioctl_addr,
    input  logic [7:0]                   ioctl_dout,
    input  logic [NUM_PLAYERS-1:0]       autofire_en,
    output logic [BTN_W*NUM_PLAYERS-1:0] btn,
    output logic [NUM_PLAYERS-1:0]       coin,
    output logic [8*NUM_DIP_BANKS-1:0]   dip,
    output logic [7:0]                   mod_id,
    output logic                         mod_valid
);

    logic                         started_q, old_toggle_q, key_event;
    key_map_t                     key_hit;
    logic [KEY_W-1:0]             key_q [NUM_PLAYERS];
    logic [15:0]                  joy_any;
    logic [BTN_W-1:0]             base_btn [NUM_PLAYERS];
    logic [BTN_W*NUM_PLAYERS-1:0] btn_q, btn_d;
    logic [8*NUM_DIP_BANKS-1:0]   dip_q;
    logic [7:0]                   mod_id_q;
    logic                         mod_valid_q;

    // The first clock after reset only captures the toggle bit.
    assign key_event = started_q && (ps2_key[10] != old_toggle_q);
    assign key_hit   = key_map(ps2_key[8], ps2_key[7:0]);

    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            started_q    <= 1'b0;
            old_toggle_q <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) key_q[p] <= '0;
        end else begin
            started_q    <= 1'b1;
            old_toggle_q <= ps2_key[10];
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int b = 0; b < KEY_W; b++) begin
                    if (key_event && key_hit.valid && key_hit.player == 2'(p) && key_hit.idx == 4'(b))
                        key_q[p][b] <= ps2_key[9];
                end
            end
        end
    end

    always_comb begin
        joy_any = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) joy_any |= joy[16*p +: 16];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            base_btn[p]            = key_q[p][BTN_W-1:0];
            base_btn[p][BTN_START] = key_q[p][BTN_START] | key_q[p][KEY_ALT_START];
            if (!joy_merge)
                base_btn[p] |= joy_to_btn(joy[16*p +: 16], p == 1);
            else if (p == 0)
                base_btn[p] |= joy_to_btn(joy_any, 1'b0);
        end
    end

`ifdef AUTOFIRE_EN
    localparam int AFW = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;

    logic [AFW-1:0]         af_cnt_q [NUM_PLAYERS];
    logic [AFW-1:0]         af_cnt_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] af_phase_q, af_phase_d, af_held_q;

    // Phase restarts high on each press and flips every AUTOFIRE_PERIOD cycles while held.
    always_comb begin
        btn_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            af_cnt_d[p]   = af_cnt_q[p];
            af_phase_d[p] = af_phase_q[p];
            if (!base_btn[p][BTN_FIRE_A]) begin
                af_cnt_d[p]   = '0;
                af_phase_d[p] = 1'b0;
            end else if (!af_held_q[p] || af_cnt_q[p] == '0) begin
                af_cnt_d[p]   = AFW'(AUTOFIRE_PERIOD - 1);
                af_phase_d[p] = !af_held_q[p] ? 1'b1 : ~af_phase_q[p];
            end else begin
                af_cnt_d[p]   = af_cnt_q[p] - AFW'(1);
            end
            btn_d[BTN_W*p +: BTN_W] = base_btn[p];
            if (autofire_en[p])
                btn_d[BTN_W*p + BTN_FIRE_A] = base_btn[p][BTN_FIRE_A] & af_phase_d[p];
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            af_phase_q <= '0;
            af_held_q  <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) af_cnt_q[p] <= '0;
        end else begin
            af_phase_q <= af_phase_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                af_cnt_q[p]  <= af_cnt_d[p];
                af_held_q[p] <= base_btn[p][BTN_FIRE_A];
            end
        end
    end
`else
    logic unused_autofire;
    assign unused_autofire = ^{autofire_en, AUTOFIRE_PERIOD > 0};

    always_comb begin
        btn_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) btn_d[BTN_W*p +: BTN_W] = base_btn[p];
    end
`endif

    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            btn_q       <= '0;
            dip_q       <= '0;
            mod_id_q    <= '0;
            mod_valid_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
            if (ioctl_wr && ioctl_index == 8'(DIP_INDEX)) begin
                for (int k = 0; k < NUM_DIP_BANKS; k++) begin
                    if (ioctl_addr == 25'(k)) dip_q[8*k +: 8] <= ioctl_dout;
                end
            end
            if (ioctl_wr && ioctl_index == 8'(MOD_INDEX)) begin
                mod_id_q    <= ioctl_dout;
                mod_valid_q <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        coin_stretcher #(
            .COIN_MIN_CYCLES(COIN_MIN_CYCLES)
        ) u_coin (
            .clk   (clk_sys),
            .rst_n (RESET_L),
            .raw_i (btn_q[BTN_W*p + BTN_COIN]),
            .coin_o(coin[p])
        );
    end

    assign btn       = btn_q;
    assign dip       = dip_q;
    assign mod_id    = mod_id_q;
    assign mod_valid = mod_valid_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - directed + random check of arcade_input_mapper against a scancode-table model
module tb_arcade_input_mapper;

    localparam int NP  = 3;
    localparam int ND  = 8;
    localparam int CMC = 10;
    localparam int AFP = 4;

    logic          clk_sys = 1'b0;
    logic          RESET_L = 1'b1;
    logic [10:0]   ps2_key = '0;
    logic [16*NP-1:0] joy  = '0;
    logic          joy_merge = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [7:0]    ioctl_index = '0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic [NP-1:0] autofire_en = '0;
    logic [12*NP-1:0] btn;
    logic [NP-1:0] coin;
    logic [8*ND-1:0] dip;
    logic [7:0]    mod_id;
    logic          mod_valid;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS(NP), .NUM_DIP_BANKS(ND), .DIP_INDEX(254), .MOD_INDEX(1),
        .COIN_MIN_CYCLES(CMC), .AUTOFIRE_PERIOD(AFP)
    ) dut (
        .clk_sys(clk_sys), .RESET_L(RESET_L), .ps2_key(ps2_key), .joy(joy),
        .joy_merge(joy_merge), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .autofire_en(autofire_en),
        .btn(btn), .coin(coin), .dip(dip), .mod_id(mod_id), .mod_valid(mod_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-scancode key table, spec key map, edge counters.
    bit          kd [512];
    int          mp [512];
    int          mb [512];
    bit          m_started;
    bit          m_tog;
    logic [12*NP-1:0] m_btn;
    logic [NP-1:0]    m_coin;
    int          last_rise [NP];
    bit          prev_raw [NP];
    int          press_at [NP];
    bit          prev_fire [NP];
    logic [8*ND-1:0] m_dip;
    logic [7:0]  m_mod;
    bit          m_modv;
    int          n = 0;
    int          coin0_acc;
    logic [8:0]  pool [26];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] jmap(input logic [15:0] j, input int p);
        int src [11];
        logic [11:0] r;
        src = '{3, 2, 1, 0, 4, 5, 7, 6, 8, 10, 11};
        r = '0;
        for (int b = 0; b < 11; b++) r[b] = j[(b == 8 && p == 1) ? 9 : src[b]];
        return r;
    endfunction

    task automatic set_map(input int code9, input int p, input int b);
        mp[code9] = p;
        mb[code9] = b;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 512; s++) kd[s] = 1'b0;
        m_started = 1'b0;
        m_btn = '0;
        m_coin = '0;
        for (int p = 0; p < NP; p++) begin
            last_rise[p] = -1000;
            prev_raw[p]  = 1'b0;
            prev_fire[p] = 1'b0;
            press_at[p]  = 0;
        end
        m_dip = '0;
        m_mod = '0;
        m_modv = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".btn"}, 64'(btn), 64'(m_btn));
        chk({tag, ".coin"}, 64'(coin), 64'(m_coin));
        chk({tag, ".dip"}, 64'(dip), 64'(m_dip));
        chk({tag, ".mod_id"}, 64'(mod_id), 64'(m_mod));
        chk({tag, ".mod_valid"}, 64'(mod_valid), 64'(m_modv));
    endtask

    task automatic step();
        logic [12*NP-1:0] nb;
        logic [15:0] jor;
        logic [11:0] kb, jb, f;
        int nn;
        nn = n + 1;
        jor = '0;
        for (int p = 0; p < NP; p++) jor |= joy[16*p +: 16];
        nb = '0;
        for (int p = 0; p < NP; p++) begin
            kb = '0;
            for (int s = 0; s < 512; s++) if (kd[s] && mp[s] == p) kb[mb[s]] = 1'b1;
            if (joy_merge) jb = (p == 0) ? jmap(jor, 0) : 12'h000;
            else           jb = jmap(joy[16*p +: 16], p);
            f = kb | jb;
            if (f[4] && !prev_fire[p]) press_at[p] = nn;
            prev_fire[p] = f[4];
`ifdef AUTOFIRE_EN
            if (autofire_en[p] && f[4] && (((nn - press_at[p]) / AFP) % 2) == 1) f[4] = 1'b0;
`endif
            nb[12*p +: 12] = f;
        end
        if (m_started && ps2_key[10] != m_tog) kd[ps2_key[8:0]] = ps2_key[9];
        m_tog = ps2_key[10];
        m_started = 1'b1;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'(ND))
            m_dip[8*int'(ioctl_addr) +: 8] = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd1) begin
            m_mod = ioctl_dout;
            m_modv = 1'b1;
        end
        @(posedge clk_sys);
        #1;
        n = nn;
        m_btn = nb;
        for (int p = 0; p < NP; p++) begin
            if (m_btn[12*p+9] && !prev_raw[p]) last_rise[p] = n;
            prev_raw[p] = m_btn[12*p+9];
            m_coin[p] = m_btn[12*p+9] || ((n - last_rise[p]) < CMC);
        end
        coin0_acc += int'(coin[0]);
        check_all("step");
    endtask

    task automatic send_key(input logic ext, input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        step();
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        ioctl_wr = 1'b1;
        ioctl_index = idx;
        ioctl_addr = addr;
        ioctl_dout = d;
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic reset_assert();
        RESET_L = 1'b0;
        #1;
        model_clear();
        check_all("reset");
    endtask

    task automatic reset_release();
        @(negedge clk_sys);
        RESET_L = 1'b1;
    endtask

    initial begin
        logic [19:0] af_seen;
        logic [19:0] af_exp;
        for (int s = 0; s < 512; s++) begin
            mp[s] = -1;
            mb[s] = 0;
        end
        set_map(9'h175, 0, 0); set_map(9'h172, 0, 1); set_map(9'h16B, 0, 2); set_map(9'h174, 0, 3);
        set_map(9'h014, 0, 4); set_map(9'h011, 0, 5); set_map(9'h029, 0, 6); set_map(9'h012, 0, 7);
        set_map(9'h005, 0, 8); set_map(9'h016, 0, 8); set_map(9'h02E, 0, 9);
        set_map(9'h02D, 1, 0); set_map(9'h02B, 1, 1); set_map(9'h023, 1, 2); set_map(9'h034, 1, 3);
        set_map(9'h01C, 1, 4); set_map(9'h01B, 1, 5); set_map(9'h015, 1, 6); set_map(9'h01D, 1, 7);
        set_map(9'h006, 1, 8); set_map(9'h01E, 1, 8); set_map(9'h036, 1, 9);
        pool = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h011, 9'h029, 9'h012, 9'h005,
                 9'h016, 9'h02E, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h015,
                 9'h01D, 9'h006, 9'h01E, 9'h036, 9'h075, 9'h114, 9'h01A, 9'h12E};
        m_tog = 1'b0;

        #2;
        reset_assert();
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
        reset_release();
        step(); step(); step();
        chk("first_clk_ignored", 64'(btn[4]), 64'd0);

        send_key(1'b0, 8'h14, 1'b1);
        chk("fireA_after_1clk", 64'(btn[4]), 64'd0);
        step();
        chk("fireA_after_2clk", 64'(btn[4]), 64'd1);
        send_key(1'b0, 8'h14, 1'b0);
        step();
        chk("fireA_released", 64'(btn[4]), 64'd0);

        joy_merge = 1'b1;
        joy[16+3] = 1'b1;
        step();
        chk("merge_p0_up", 64'(btn[0]), 64'd1);
        chk("merge_p1_zero", 64'(btn[23:12]), 64'd0);
        joy_merge = 1'b0;
        step();
        chk("nomerge_p1_up", 64'(btn[12]), 64'd1);
        chk("nomerge_p0_up", 64'(btn[0]), 64'd0);
        joy = '0;
        step();

        coin0_acc = 0;
        send_key(1'b0, 8'h2E, 1'b1);
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (20) step();
        chk("coin_single_len", 64'(coin0_acc), 64'd10);

        coin0_acc = 0;
        send_key(1'b0, 8'h2E, 1'b1);
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (3) step();
        send_key(1'b0, 8'h2E, 1'b1);
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (20) step();
        chk("coin_retrigger_len", 64'(coin0_acc), 64'd15);

        for (int a = 0; a <= 8; a++) ioctl_write(8'd254, 25'(a), 8'hA0 + 8'(a));
        ioctl_write(8'd254, 25'h100, 8'h55);
        step();
        chk("dip_banks", 64'(dip), 64'hA7A6A5A4A3A2A1A0);

        ioctl_write(8'd1, 25'd0, 8'h03);
        ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h74};
        ioctl_write(8'd1, 25'd1, 8'h02);
        step();
        chk("mod_last_wins", 64'(mod_id), 64'h02);
        chk("mod_valid_set", 64'(mod_valid), 64'd1);
        chk("key_with_ioctl", 64'(btn[3]), 64'd1);

        ioctl_wr = 1'b1; ioctl_index = 8'd254; ioctl_addr = 25'd3; ioctl_dout = 8'hEE;
        reset_assert();
        chk("reset_mid_mod", 64'(mod_id), 64'h00);
        chk("reset_mid_dip", 64'(dip), 64'h0);
        ioctl_wr = 1'b0;
        reset_release();
        step();

        autofire_en = 3'b001;
        joy[4] = 1'b1;
        af_seen = '0;
        for (int i = 19; i >= 0; i--) begin
            step();
            af_seen[i] = btn[4];
        end
`ifdef AUTOFIRE_EN
        af_exp = 20'b1111_0000_1111_0000_1111;
`else
        af_exp = 20'hFFFFF;
`endif
        chk("autofire_pattern", 64'(af_seen), 64'(af_exp));
        joy[4] = 1'b0;
        step();
        chk("autofire_release", 64'(btn[4]), 64'd0);

        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                reset_assert();
                reset_release();
            end
            if ($urandom_range(0, 9) < 4) begin
                logic [8:0] k;
                k = pool[$urandom_range(0, 25)];
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), k};
            end
            if ($urandom_range(0, 3) == 0)
                joy = 48'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) joy_merge = ~joy_merge;
            if ($urandom_range(0, 7) == 0) autofire_en = 3'($urandom);
            ioctl_wr = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: ioctl_index = 8'd1;
                1: ioctl_index = 8'd254;
                2: ioctl_index = 8'd7;
                default: ioctl_index = 8'd253;
            endcase
            ioctl_addr = ($urandom_range(0, 3) == 0) ? 25'h100 + 25'($urandom_range(0, 7))
                                                      : 25'($urandom_range(0, 9));
            ioctl_dout = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
